// File: rtl/button_conditioner.sv
// button_conditioner
// Turns raw, bouncy, asynchronous push-button pins into clean clk-domain
// signals. Each button has its own independent pipeline:
//   2-FF synchronizer -> polarity normalisation -> stable-time debouncer
//   -> registered press/release pulses -> auto-repeat FSM.
// btn_level is active-high (1 = pressed) whatever the pin polarity.

module button_conditioner #(
   parameter int NUM_BTN         = 2,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_repeat
);

   // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
   localparam int DEB_CLOG = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DEB_W    = (DEB_CLOG < 1) ? 1 : DEB_CLOG;

   // Repeat counter covers the longer of the two repeat intervals.
   localparam int REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_CLOG = $clog2(REP_MAX + 1);
   localparam int REP_W    = (REP_CLOG < 1) ? 1 : REP_CLOG;

   // Pin value that means "not pressed"; synchronizers reset to it so that
   // leaving reset never looks like a press.
   localparam logic RELEASED_PIN = ACTIVE_LOW;

   // A zero delay turns auto-repeat off entirely.
   localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

   localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
   localparam logic [DEB_W-1:0] DEB_ZERO    = DEB_W'(0);
   localparam logic [DEB_W-1:0] DEB_ONE     = DEB_W'(1);
   localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
   localparam logic [REP_W-1:0] REP_ZERO    = REP_W'(0);
   localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn

      logic             sync1_r;
      logic             sync2_r;
      logic             pressed_s;

      logic             level_r;
      logic             level_nxt_s;
      logic [DEB_W-1:0] deb_cnt_r;
      logic [DEB_W-1:0] deb_cnt_nxt_s;
      logic             rise_s;
      logic             fall_s;

      logic             press_r;
      logic             release_r;

      rep_state_t       state_r;
      rep_state_t       state_nxt_s;
      logic [REP_W-1:0] rep_cnt_r;
      logic [REP_W-1:0] rep_cnt_nxt_s;
      logic             repeat_r;
      logic             repeat_nxt_s;

      // Two-flop synchronizer bringing the asynchronous pin into clk domain.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync1_r <= RELEASED_PIN;
            sync2_r <= RELEASED_PIN;
         end else begin
            sync1_r <= btn_raw[b];
            sync2_r <= sync1_r;
         end
      end

      // Normalise polarity: pressed_s is 1 while the button is held.
      assign pressed_s = sync2_r ^ ACTIVE_LOW;

      // Debounce: accept a new level only after it has differed from the
      // current level for DEBOUNCE_CYCLES consecutive cycles; any return to
      // the old level restarts qualification from zero.
      always_comb begin
         level_nxt_s   = level_r;
         deb_cnt_nxt_s = deb_cnt_r;
         rise_s        = 1'b0;
         fall_s        = 1'b0;
         if (pressed_s == level_r) begin
            deb_cnt_nxt_s = DEB_ZERO;
         end else if (deb_cnt_r == DEB_LAST) begin
            level_nxt_s   = pressed_s;
            deb_cnt_nxt_s = DEB_ZERO;
            rise_s        = pressed_s;
            fall_s        = ~pressed_s;
         end else begin
            deb_cnt_nxt_s = deb_cnt_r + DEB_ONE;
         end
      end

      // Debounced level plus press/release pulses registered on the same
      // edge, so each pulse lines up with the first cycle of the new level.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            level_r   <= 1'b0;
            deb_cnt_r <= DEB_ZERO;
            press_r   <= 1'b0;
            release_r <= 1'b0;
         end else begin
            level_r   <= level_nxt_s;
            deb_cnt_r <= deb_cnt_nxt_s;
            press_r   <= rise_s;
            release_r <= fall_s;
         end
      end

      // Auto-repeat next state. The FSM leaves IDLE on the same edge that
      // raises btn_level, so the DELAY count starts in the btn_press cycle
      // and the registered repeat pulse lands exactly REPEAT_DELAY cycles
      // later. A release always wins and suppresses any pending pulse.
      always_comb begin
         state_nxt_s   = state_r;
         rep_cnt_nxt_s = rep_cnt_r;
         repeat_nxt_s  = 1'b0;
         if (fall_s) begin
            state_nxt_s   = ST_IDLE;
            rep_cnt_nxt_s = REP_ZERO;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (rise_s && REPEAT_EN) begin
                     state_nxt_s   = ST_DELAY;
                     rep_cnt_nxt_s = REP_ZERO;
                  end else begin
                     state_nxt_s   = ST_IDLE;
                     rep_cnt_nxt_s = REP_ZERO;
                  end
               end
               ST_DELAY: begin
                  if (rep_cnt_r == DELAY_LAST) begin
                     repeat_nxt_s  = 1'b1;
                     state_nxt_s   = ST_REPEAT;
                     rep_cnt_nxt_s = REP_ZERO;
                  end else begin
                     rep_cnt_nxt_s = rep_cnt_r + REP_ONE;
                  end
               end
               ST_REPEAT: begin
                  if (rep_cnt_r == PERIOD_LAST) begin
                     repeat_nxt_s  = 1'b1;
                     rep_cnt_nxt_s = REP_ZERO;
                  end else begin
                     rep_cnt_nxt_s = rep_cnt_r + REP_ONE;
                  end
               end
               default: begin
                  state_nxt_s   = ST_IDLE;
                  rep_cnt_nxt_s = REP_ZERO;
               end
            endcase
         end
      end

      // Auto-repeat state, counter and registered repeat pulse.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_r   <= ST_IDLE;
            rep_cnt_r <= REP_ZERO;
            repeat_r  <= 1'b0;
         end else begin
            state_r   <= state_nxt_s;
            rep_cnt_r <= rep_cnt_nxt_s;
            repeat_r  <= repeat_nxt_s;
         end
      end

      assign btn_level[b]   = level_r;
      assign btn_press[b]   = press_r;
      assign btn_release[b] = release_r;
      assign btn_repeat[b]  = repeat_r;

   end : g_btn

   button_conditioner_checker #(
      .NUM_BTN (NUM_BTN)
   ) u_checker (
      .clk         (clk),
      .rst         (rst),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_repeat  (btn_repeat)
   );

endmodule

// button_conditioner_checker
// Output-relationship properties that must hold for every button.
module button_conditioner_checker #(
   parameter int NUM_BTN = 2
) (
   input logic               clk,
   input logic               rst,
   input logic [NUM_BTN-1:0] btn_level,
   input logic [NUM_BTN-1:0] btn_press,
   input logic [NUM_BTN-1:0] btn_release,
   input logic [NUM_BTN-1:0] btn_repeat
);

   localparam logic [NUM_BTN-1:0] NONE = '0;

   // A press pulse never coincides with a repeat pulse.
   a_press_not_repeat: assert property (@(posedge clk) disable iff (rst)
      ((btn_press & btn_repeat) == NONE));

   // A release pulse never coincides with a repeat pulse.
   a_release_not_repeat: assert property (@(posedge clk) disable iff (rst)
      ((btn_release & btn_repeat) == NONE));

   // Press pulses only while the debounced level is high.
   a_press_level: assert property (@(posedge clk) disable iff (rst)
      ((btn_press & ~btn_level) == NONE));

   // Release pulses only while the debounced level is low.
   a_release_level: assert property (@(posedge clk) disable iff (rst)
      ((btn_release & btn_level) == NONE));

   // Repeat pulses only while the button is held.
   a_repeat_level: assert property (@(posedge clk) disable iff (rst)
      ((btn_repeat & ~btn_level) == NONE));

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with a short debounce and
// repeat configuration: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.

module tb_button_conditioner;

   logic       clk;
   logic       rst;
   logic [1:0] btn_raw;
   logic [1:0] btn_level;
   logic [1:0] btn_press;
   logic [1:0] btn_release;
   logic [1:0] btn_repeat;

   int checks = 0;
   int errors = 0;

   button_conditioner #(
      .NUM_BTN         (2),
      .ACTIVE_LOW      (1'b1),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_repeat  (btn_repeat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      btn_raw = 2'b11;
      repeat (3) tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !== 8'h00) begin
         errors++;
         $display("FAIL reset_hold: got lvl=%b prs=%b rel=%b rep=%b, want all 0",
                  btn_level, btn_press, btn_release, btn_repeat);
      end
      rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle c%0d: got lvl=%b prs=%b rel=%b rep=%b, want all 0",
                     i, btn_level, btn_press, btn_release, btn_repeat);
         end
      end
   endtask

   task automatic test_press_release();
      btn_raw = 2'b10;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (btn_level !== 2'b00 || btn_press !== 2'b00) begin
            errors++;
            $display("FAIL press_early c%0d: got lvl=%b prs=%b, want 00 00", i, btn_level, btn_press);
         end
      end
      tick();
      checks++;
      if (btn_level !== 2'b01 || btn_press !== 2'b01 || btn_release !== 2'b00) begin
         errors++;
         $display("FAIL press_edge: got lvl=%b prs=%b rel=%b, want 01 01 00",
                  btn_level, btn_press, btn_release);
      end
      tick();
      checks++;
      if (btn_level !== 2'b01 || btn_press !== 2'b00) begin
         errors++;
         $display("FAIL press_one_cycle: got lvl=%b prs=%b, want 01 00", btn_level, btn_press);
      end
      btn_raw = 2'b11;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (btn_level !== 2'b01 || btn_release !== 2'b00 || btn_repeat !== 2'b00) begin
            errors++;
            $display("FAIL release_early c%0d: got lvl=%b rel=%b rep=%b, want 01 00 00",
                     i, btn_level, btn_release, btn_repeat);
         end
      end
      tick();
      checks++;
      if (btn_level !== 2'b00 || btn_release !== 2'b01 || btn_press !== 2'b00) begin
         errors++;
         $display("FAIL release_edge: got lvl=%b rel=%b prs=%b, want 00 01 00",
                  btn_level, btn_release, btn_press);
      end
      tick();
      checks++;
      if (btn_release !== 2'b00) begin
         errors++;
         $display("FAIL release_one_cycle: got rel=%b, want 00", btn_release);
      end
      repeat (4) tick();
   endtask

   task automatic test_bounce();
      btn_raw = 2'b11;
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) btn_raw[0] = ~btn_raw[0];
         tick();
         checks++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== 8'h00) begin
            errors++;
            $display("FAIL bounce c%0d: got lvl=%b prs=%b rel=%b rep=%b, want all 0",
                     i, btn_level, btn_press, btn_release, btn_repeat);
         end
      end
      btn_raw = 2'b11;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== 8'h00) begin
            errors++;
            $display("FAIL bounce_settle c%0d: got lvl=%b prs=%b rel=%b rep=%b, want all 0",
                     i, btn_level, btn_press, btn_release, btn_repeat);
         end
      end
   endtask

   // Press btn0, hold through several repeats, release so the debounced fall
   // lands on cycle 35, exactly where a repeat would otherwise be due.
   task automatic test_repeat_hold();
      logic [1:0] exp_rep;
      logic [1:0] exp_rel;
      logic [1:0] exp_lvl;
      btn_raw = 2'b10;
      repeat (5) tick();
      tick();
      checks++;
      if (btn_press !== 2'b01 || btn_repeat !== 2'b00) begin
         errors++;
         $display("FAIL hold_press: got prs=%b rep=%b, want 01 00", btn_press, btn_repeat);
      end
      for (int c = 1; c <= 45; c++) begin
         tick();
         exp_rep = (c == 10 || c == 15 || c == 20 || c == 25 || c == 30) ? 2'b01 : 2'b00;
         exp_rel = (c == 35) ? 2'b01 : 2'b00;
         exp_lvl = (c < 35) ? 2'b01 : 2'b00;
         checks++;
         if (btn_repeat !== exp_rep || btn_release !== exp_rel ||
             btn_level !== exp_lvl || btn_press !== 2'b00) begin
            errors++;
            $display("FAIL hold c%0d: got rep=%b rel=%b lvl=%b prs=%b, want %b %b %b 00",
                     c, btn_repeat, btn_release, btn_level, btn_press, exp_rep, exp_rel, exp_lvl);
         end
         if (c == 29) btn_raw = 2'b11;
      end
   endtask

   task automatic test_both_buttons();
      logic [1:0] exp_rep;
      logic [1:0] exp_rel;
      logic [1:0] exp_lvl;
      btn_raw = 2'b00;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (btn_press !== 2'b00) begin
            errors++;
            $display("FAIL both_early c%0d: got prs=%b, want 00", i, btn_press);
         end
      end
      tick();
      checks++;
      if (btn_press !== 2'b11 || btn_level !== 2'b11) begin
         errors++;
         $display("FAIL both_press: got prs=%b lvl=%b, want 11 11", btn_press, btn_level);
      end
      for (int c = 1; c <= 25; c++) begin
         tick();
         exp_rep = (c == 10 || c == 15) ? 2'b11 : 2'b00;
         exp_rel = (c == 17) ? 2'b11 : 2'b00;
         exp_lvl = (c < 17) ? 2'b11 : 2'b00;
         checks++;
         if (btn_repeat !== exp_rep || btn_release !== exp_rel ||
             btn_level !== exp_lvl || btn_press !== 2'b00) begin
            errors++;
            $display("FAIL both c%0d: got rep=%b rel=%b lvl=%b prs=%b, want %b %b %b 00",
                     c, btn_repeat, btn_release, btn_level, btn_press, exp_rep, exp_rel, exp_lvl);
         end
         if (c == 11) btn_raw = 2'b11;
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [1:0] exp_rep;
      btn_raw = 2'b10;
      repeat (6) tick();
      checks++;
      if (btn_press !== 2'b01) begin
         errors++;
         $display("FAIL midrst_first_press: got prs=%b, want 01", btn_press);
      end
      for (int c = 1; c <= 12; c++) begin
         tick();
         exp_rep = (c == 10) ? 2'b01 : 2'b00;
         checks++;
         if (btn_repeat !== exp_rep || btn_level !== 2'b01) begin
            errors++;
            $display("FAIL midrst_hold c%0d: got rep=%b lvl=%b, want %b 01",
                     c, btn_repeat, btn_level, exp_rep);
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !== 8'h00) begin
         errors++;
         $display("FAIL midrst_async: got lvl=%b prs=%b rel=%b rep=%b, want all 0",
                  btn_level, btn_press, btn_release, btn_repeat);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== 8'h00) begin
            errors++;
            $display("FAIL midrst_held c%0d: got lvl=%b prs=%b rel=%b rep=%b, want all 0",
                     i, btn_level, btn_press, btn_release, btn_repeat);
         end
      end
      rst = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         tick();
         checks++;
         if (btn_press !== 2'b00 || btn_level !== 2'b00) begin
            errors++;
            $display("FAIL midrst_requal e%0d: got prs=%b lvl=%b, want 00 00", e, btn_press, btn_level);
         end
      end
      tick();
      checks++;
      if (btn_press !== 2'b01 || btn_level !== 2'b01) begin
         errors++;
         $display("FAIL midrst_repress: got prs=%b lvl=%b, want 01 01", btn_press, btn_level);
      end
      for (int c = 1; c <= 12; c++) begin
         tick();
         exp_rep = (c == 10) ? 2'b01 : 2'b00;
         checks++;
         if (btn_repeat !== exp_rep || btn_press !== 2'b00) begin
            errors++;
            $display("FAIL midrst_repeat c%0d: got rep=%b prs=%b, want %b 00",
                     c, btn_repeat, btn_press, exp_rep);
         end
      end
      btn_raw = 2'b11;
      repeat (10) tick();
      checks++;
      if (btn_level !== 2'b00) begin
         errors++;
         $display("FAIL midrst_final_release: got lvl=%b, want 00", btn_level);
      end
   endtask

   initial begin
      rst     = 1'b1;
      btn_raw = 2'b11;
      test_reset();
      test_press_release();
      test_bounce();
      test_repeat_hold();
      test_both_buttons();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
